// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - operand sequencer feeding one GenericMacUnit
//
// Purpose: on a start pulse, reads ACC_CYCLES operand pairs from two
// synchronous-read memories. It streams them into a MAC as newData pulses,
// captures the accumulated result and offers it on a valid/ready handshake.
//
// Optional feature macro: SEQ_PAUSE_EN (adds the pause input; stalls read issue).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, base_a, base_b      run request and memory start addresses
//   mem_a_addr, mem_b_addr     memory read addresses
//   mem_rd                     shared read enable
//   mem_a_rdata, mem_b_rdata   memory read data (one cycle after mem_rd)
//   mac_reset, mac_newData     MAC control
//   mac_operandA, mac_operandB MAC operands
//   mac_AccResult              MAC accumulated result
//   pause                      issue stall (SEQ_PAUSE_EN only)
//   busy                       run in progress
//   result, result_valid       captured sum, valid while waiting for accept
//   result_ready               downstream accept
//
// ACC_LAT must be at least 1.

module mac_operand_sequencer #(
  parameter int BW_A       = 8,
  parameter int BW_B       = 8,
  parameter int ACC_CYCLES = 400,
  parameter int BW_ACC     = 25,
  parameter int ADDR_W     = 9,
  parameter int ACC_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  output logic              mem_rd,
  input  logic [BW_A-1:0]   mem_a_rdata,
  input  logic [BW_B-1:0]   mem_b_rdata,
  output logic              mac_reset,
  output logic              mac_newData,
  output logic [BW_A-1:0]   mac_operandA,
  output logic [BW_B-1:0]   mac_operandB,
  input  logic [BW_ACC-1:0] mac_AccResult,
`ifdef SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic              busy,
  output logic [BW_ACC-1:0] result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int NW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam int LW = (ACC_LAT > 1) ? $clog2(ACC_LAT + 1) : 1;
  localparam logic [NW-1:0] N_LAST   = NW'(ACC_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(ACC_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] baseA;
  logic [ADDR_W-1:0] baseB;
  logic [NW-1:0]     n;
  logic [LW-1:0]     latCnt;
  logic              clr;
  logic              rdPend;   // read issued last cycle, data on rdata now
  logic              stall;

`ifdef SEQ_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign mac_reset = reset | clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      baseA        <= '0;
      baseB        <= '0;
      n            <= '0;
      latCnt       <= '0;
      clr          <= 1'b0;
      rdPend       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_a_addr   <= '0;
      mem_b_addr   <= '0;
      mac_newData  <= 1'b0;
      mac_operandA <= '0;
      mac_operandB <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      clr         <= 1'b0;
      rdPend      <= mem_rd;
      mac_newData <= rdPend;
      if (rdPend) begin
        mac_operandA <= mem_a_rdata;
        mac_operandB <= mem_b_rdata;
      end

      case (state)
        IDLE: begin
          if (start) begin
            // Read 0 is issued straight from IDLE so the first newData lands
            // three cycles after start; n then tracks the next index to issue.
            baseA      <= base_a;
            baseB      <= base_b;
            clr        <= 1'b1;
            busy       <= 1'b1;
            mem_rd     <= 1'b1;
            mem_a_addr <= base_a;
            mem_b_addr <= base_b;
            n          <= NW'(1);
            latCnt     <= '0;
            state      <= (ACC_CYCLES == 1) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (stall) begin
            mem_rd <= 1'b0;
          end else begin
            mem_rd     <= 1'b1;
            mem_a_addr <= baseA + ADDR_W'(n);
            mem_b_addr <= baseB + ADDR_W'(n);
            if (n == N_LAST) state <= DRAIN;
            else             n     <= n + NW'(1);
          end
        end
        DRAIN: begin
          mem_rd <= 1'b0;
          // Empty once the last read has left every stage, including newData.
          if (!mem_rd && !rdPend && !mac_newData) begin
            if (latCnt == LAT_LAST) begin
              result       <= mac_AccResult;
              result_valid <= 1'b1;
              state        <= HOLD;
            end else begin
              latCnt <= latCnt + LW'(1);
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb/tb_mac_operand_sequencer.sv - directed bench for mac_operand_sequencer
module tb_mac_operand_sequencer;

  localparam int BW_A = 8;
  localparam int BW_B = 8;
  localparam int ACC_CYCLES = 4;
  localparam int BW_ACC = 25;
  localparam int ADDR_W = 2;
  localparam int ACC_LAT = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_a, base_b;
  logic [ADDR_W-1:0] mem_a_addr, mem_b_addr;
  logic              mem_rd;
  logic [BW_A-1:0]   mem_a_rdata;
  logic [BW_B-1:0]   mem_b_rdata;
  logic              mac_reset, mac_newData;
  logic [BW_A-1:0]   mac_operandA;
  logic [BW_B-1:0]   mac_operandB;
  logic [BW_ACC-1:0] mac_AccResult;
  logic              pause;
  logic              busy;
  logic [BW_ACC-1:0] result;
  logic              result_valid, result_ready;

  logic [BW_A-1:0] memA [4];
  logic [BW_B-1:0] memB [4];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int startCyc;
  int seen;
  int pulseCyc [$];
  int addrLogA [$];

  always #5 clk = ~clk;

  mac_operand_sequencer #(
    .BW_A(BW_A), .BW_B(BW_B), .ACC_CYCLES(ACC_CYCLES),
    .BW_ACC(BW_ACC), .ADDR_W(ADDR_W), .ACC_LAT(ACC_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_a(base_a), .base_b(base_b),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr), .mem_rd(mem_rd),
    .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
    .mac_reset(mac_reset), .mac_newData(mac_newData),
    .mac_operandA(mac_operandA), .mac_operandB(mac_operandB),
    .mac_AccResult(mac_AccResult),
`ifdef SEQ_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_a_rdata <= memA[mem_a_addr];
      mem_b_rdata <= memB[mem_b_addr];
    end
  end

  // Reference MAC: one-cycle accumulate on newData.
  always @(posedge clk) begin
    if (mac_reset) mac_AccResult <= '0;
    else if (mac_newData)
      mac_AccResult <= mac_AccResult + BW_ACC'(mac_operandA) * BW_ACC'(mac_operandB);
  end

  always @(negedge clk) begin
    if (mac_newData) pulseCyc.push_back(cyc);
    if (mem_rd) addrLogA.push_back(int'(mem_a_addr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic runStart(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb);
    pulseCyc.delete();
    addrLogA.delete();
    base_a = ba;
    base_b = bb;
    start = 1'b1;
    startCyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (result_valid) break;
      tick();
    end
    check(tag, {31'd0, result_valid}, 32'd1);
  endtask

  task automatic acceptResult();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_a = '0; base_b = '0;
    pause = 1'b0; result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memA[i] = 8'(i + 1);
      memB[i] = 8'd2;
    end
    repeat (3) tick();

    // Reset state
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_newData", {31'd0, mac_newData}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_addr", {30'd0, mem_a_addr}, 32'd0);
    check("rst_opA", {24'd0, mac_operandA}, 32'd0);
    check("rst_mac_reset", {31'd0, mac_reset}, 32'd1);
    reset = 1'b0;
    tick();
    check("mac_reset_low", {31'd0, mac_reset}, 32'd0);

    // Basic run (1..4 x 2 = 20), repeated start during ISSUE
    runStart(2'd0, 2'd0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("clr_pulse", {31'd0, mac_reset}, 32'd1);
    tick();
    check("clr_one_cycle", {31'd0, mac_reset}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    waitValid("t1_valid_timeout");
    check("t1_result", 32'(result), 32'd20);

    // Hold with ready low; a start during HOLD is ignored
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      check("hold_result", 32'(result), 32'd20);
      check("hold_valid", {31'd0, result_valid}, 32'd1);
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    // start coincident with handshake is ignored
    start = 1'b1;
    acceptResult();
    start = 1'b0;
    check("post_hs_valid", {31'd0, result_valid}, 32'd0);
    check("post_hs_busy", {31'd0, busy}, 32'd0);
    check("post_hs_result", 32'(result), 32'd20);
    repeat (8) tick();
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    check("t1_pulse_count", 32'(pulseCyc.size()), 32'd4);
    if (pulseCyc.size() == 4) begin
      check("t1_first_pulse", 32'(pulseCyc[0] - startCyc), 32'd3);
      check("t1_contiguous", 32'(pulseCyc[3] - pulseCyc[0]), 32'd3);
    end
    check("t1_read_count", 32'(addrLogA.size()), 32'd4);

    // Address wrap: base_a=3 -> 3,0,1,2; pairs (4,5)(1,6)(2,7)(3,8) = 64
    for (int i = 0; i < 4; i++) memB[i] = 8'(i + 5);
    runStart(2'd3, 2'd0);
    waitValid("t4_valid_timeout");
    check("t4_result", 32'(result), 32'd64);
    check("t4_read_count", 32'(addrLogA.size()), 32'd4);
    if (addrLogA.size() == 4) begin
      check("t4_addr0", 32'(addrLogA[0]), 32'd3);
      check("t4_addr1", 32'(addrLogA[1]), 32'd0);
      check("t4_addr3", 32'(addrLogA[3]), 32'd2);
    end
    acceptResult();

    // Reset at the 2nd newData aborts the run
    runStart(2'd0, 2'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (mac_newData) seen++;
      if (seen == 2) break;
      tick();
    end
    check("t5_second_pulse_seen", 32'(seen), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_newData_off", {31'd0, mac_newData}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    repeat (8) tick();
    check("t5_no_more_pulses", 32'(pulseCyc.size()), 32'd2);
    check("t5_valid", {31'd0, result_valid}, 32'd0);
    // Fresh run: 1*5+2*6+3*7+4*8 = 70
    runStart(2'd0, 2'd0);
    waitValid("t5b_valid_timeout");
    check("t5b_result", 32'(result), 32'd70);
    check("t5b_pulse_count", 32'(pulseCyc.size()), 32'd4);
    acceptResult();

`ifdef SEQ_PAUSE_EN
    // Pause 3 cycles mid-ISSUE: still 4 pulses, with a gap; 1..4 x 2 = 20
    for (int i = 0; i < 4; i++) memB[i] = 8'd2;
    runStart(2'd0, 2'd0);
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    waitValid("t6_valid_timeout");
    check("t6_result", 32'(result), 32'd20);
    check("t6_pulse_count", 32'(pulseCyc.size()), 32'd4);
    if (pulseCyc.size() == 4)
      check("t6_gap", {31'd0, (pulseCyc[3] - pulseCyc[0]) > 3}, 32'd1);
    acceptResult();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
